// File: rtl/seg7_out_driver_if.sv
// seg7_out_driver_if: processor-out bus into the display driver and the pins it drives
interface seg7_out_driver_if;
  logic [15:0] data_in;
  logic wr_en;
  logic halt;
  logic [7:0] seg;
  logic [3:0] an;
  modport master (output data_in, wr_en, halt, input seg, an);
  modport slave (input data_in, wr_en, halt, output seg, an);
endinterface

// File: rtl/seg7_out_driver.sv
// seg7_out_driver: latches the out bus and scans it as four hex digits onto a 7-segment display
module seg7_out_driver #(
  parameter int SCAN_DIV = 50000,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit LZB = 1'b0
) (
  input logic clk,
  input logic rst_n,
  seg7_out_driver_if.slave bus
);
  localparam logic [15:0] LAST = 16'(SCAN_DIV - 1);
  localparam logic [6:0] LUT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [15:0] disp_reg, presc;
  logic shown;
  logic [1:0] dig;
  logic [3:0] nib;
  logic blank;
  logic [7:0] seg_n;
  logic [3:0] an_n;
  // Leading-zero test: digit i is blank when every nibble from i upward is zero.
  always_comb begin
    nib = disp_reg[{dig, 2'b00} +: 4];
    blank = !shown || (LZB && dig != 2'd0 && (disp_reg >> {dig, 2'b00}) == 16'h0);
    seg_n = {dig == 2'd0 && bus.halt, blank ? 7'h00 : LUT[nib]};
    an_n = 4'b0001 << dig;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_reg <= '0;
      shown <= 1'b0;
      presc <= '0;
      dig <= '0;
      bus.an <= ACTIVE_LOW ? 4'b1110 : 4'b0001;
      bus.seg <= ACTIVE_LOW ? 8'hFF : 8'h00;
    end else begin
      if (bus.wr_en) begin
        disp_reg <= bus.data_in;
        shown <= 1'b1;
      end
      presc <= presc == LAST ? 16'h0 : presc + 16'h1;
      if (presc == LAST) dig <= dig + 2'd1;
      bus.an <= ACTIVE_LOW ? ~an_n : an_n;
      bus.seg <= ACTIVE_LOW ? ~seg_n : seg_n;
    end
  end
endmodule

// File: tb/tb_seg7_out_driver.sv
// tb_seg7_out_driver: directed checks of three driver configurations on a shared clock and reset
module tb_seg7_out_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  seg7_out_driver_if if0 ();
  seg7_out_driver_if if1 ();
  seg7_out_driver_if if2 ();
  seg7_out_driver #(.SCAN_DIV(4), .ACTIVE_LOW(1'b1), .LZB(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  seg7_out_driver #(.SCAN_DIV(4), .ACTIVE_LOW(1'b1), .LZB(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  seg7_out_driver #(.SCAN_DIV(1), .ACTIVE_LOW(1'b0), .LZB(1'b0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic run_to(input int n);
    repeat (n - cyc) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask
  initial begin
    {if0.data_in, if0.wr_en, if0.halt} = '0;
    {if1.data_in, if1.wr_en, if1.halt} = '0;
    {if2.data_in, if2.wr_en, if2.halt} = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an0", {4'h0, if0.an}, 8'h0E);
    chk("rst_seg0", if0.seg, 8'hFF);
    chk("rst_an2", {4'h0, if2.an}, 8'h01);
    chk("rst_seg2", if2.seg, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    run_to(1);
    chk("scan_an_e1", {4'h0, if0.an}, 8'h0E);
    chk("blank_e1", if0.seg, 8'hFF);
    run_to(4);
    chk("scan_an_e4", {4'h0, if0.an}, 8'h0E);
    run_to(5);
    chk("scan_an_e5", {4'h0, if0.an}, 8'h0D);
    run_to(9);
    chk("scan_an_e9", {4'h0, if0.an}, 8'h0B);
    run_to(13);
    chk("scan_an_e13", {4'h0, if0.an}, 8'h07);
    chk("blank_e13", if0.seg, 8'hFF);
    run_to(17);
    chk("scan_wrap_e17", {4'h0, if0.an}, 8'h0E);
    if0.data_in = 16'h1A3F;
    if0.wr_en = 1'b1;
    if1.data_in = 16'h0050;
    if1.wr_en = 1'b1;
    run_to(18);
    if0.wr_en = 1'b0;
    if1.wr_en = 1'b0;
    chk("wr_latency", if0.seg, 8'hFF);
    run_to(19);
    chk("wr_dig0_F", if0.seg, 8'h8E);
    chk("lzb_dig0_0", if1.seg, 8'hC0);
    if2.data_in = 16'h4321;
    if2.wr_en = 1'b1;
    run_to(20);
    if2.wr_en = 1'b0;
    chk("sd1_pre_an", {4'h0, if2.an}, 8'h08);
    chk("sd1_pre_seg", if2.seg, 8'h00);
    run_to(21);
    chk("dig1_an", {4'h0, if0.an}, 8'h0D);
    chk("dig1_3", if0.seg, 8'hB0);
    chk("lzb_dig1_5", if1.seg, 8'h92);
    chk("sd1_an_0", {4'h0, if2.an}, 8'h01);
    chk("sd1_seg_0", if2.seg, 8'h06);
    run_to(22);
    chk("sd1_an_1", {4'h0, if2.an}, 8'h02);
    chk("sd1_seg_1", if2.seg, 8'h5B);
    run_to(23);
    chk("sd1_an_2", {4'h0, if2.an}, 8'h04);
    chk("sd1_seg_2", if2.seg, 8'h4F);
    run_to(24);
    chk("sd1_an_3", {4'h0, if2.an}, 8'h08);
    chk("sd1_seg_3", if2.seg, 8'h66);
    run_to(25);
    chk("sd1_an_wrap", {4'h0, if2.an}, 8'h01);
    chk("dig2_A", if0.seg, 8'h88);
    chk("lzb_dig2", if1.seg, 8'hFF);
    run_to(29);
    chk("dig3_1", if0.seg, 8'hF9);
    chk("lzb_dig3", if1.seg, 8'hFF);
    if0.data_in = 16'h0007;
    if0.wr_en = 1'b1;
    if0.halt = 1'b1;
    if1.data_in = 16'h0000;
    if1.wr_en = 1'b1;
    run_to(30);
    if0.wr_en = 1'b0;
    if1.wr_en = 1'b0;
    run_to(33);
    chk("halt_an", {4'h0, if0.an}, 8'h0E);
    chk("halt_dig0", if0.seg, 8'h78);
    chk("lzb0_dig0", if1.seg, 8'hC0);
    run_to(37);
    chk("halt_dig1", if0.seg, 8'hC0);
    chk("lzb0_dig1", if1.seg, 8'hFF);
    run_to(41);
    chk("halt_dig2_an", {4'h0, if0.an}, 8'h0B);
    chk("halt_dig2", if0.seg, 8'hC0);
    chk("lzb0_dig2", if1.seg, 8'hFF);
    if0.data_in = 16'hBEEF;
    if0.wr_en = 1'b1;
    if0.halt = 1'b0;
    run_to(42);
    if0.wr_en = 1'b0;
    run_to(43);
    chk("beef_dig2", if0.seg, 8'h86);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_an", {4'h0, if0.an}, 8'h0E);
    chk("async_seg", if0.seg, 8'hFF);
    chk("async_an2", {4'h0, if2.an}, 8'h01);
    chk("async_seg2", if2.seg, 8'h00);
    if0.halt = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("hold_an", {4'h0, if0.an}, 8'h0E);
    chk("hold_seg", if0.seg, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    run_to(1);
    chk("rel_an", {4'h0, if0.an}, 8'h0E);
    chk("rel_halt_dp", if0.seg, 8'h7F);
    if0.halt = 1'b0;
    run_to(2);
    chk("rel_blank", if0.seg, 8'hFF);
    run_to(5);
    chk("rel_an_e5", {4'h0, if0.an}, 8'h0D);
    chk("rel_blank_e5", if0.seg, 8'hFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg7_out_driver.md
Name: seg7_out_driver

Overview:
- Downstream consumer of the processor's 16-bit `out` bus.
- Latches the value on a write strobe issued by the Output control path.
- Time-multiplexes the latched value as four hex digits onto a common-segment 7-segment display, with a halt indicator on the digit-0 decimal point.
- Sits between the processor top and the board pins.

Parameters:
- SCAN_DIV, 50000: clock cycles each digit stays enabled. Legal range 1..65535.
- ACTIVE_LOW, 1: 1 means `seg` and `an` are driven active-low; 0 means active-high.
- LZB, 0: 1 enables leading-zero blanking on digits 3..1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_in  input  16  value from the processor `out` bus.
- wr_en  input  1  write strobe; `data_in` is sampled on the clk edge where wr_en=1.
- halt  input  1  processor halted/not executing; lights the digit-0 decimal point.
- seg  output  8  {dp,g,f,e,d,c,b,a}, registered.
- an  output  4  digit enables, one-hot in active polarity; bit i selects digit i; digit 0 is the least significant nibble.

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0:
  - disp_reg=0, shown=0, presc=0, dig=0.
  - `an` = digit 0 enabled: 4'b1110 if ACTIVE_LOW, else 4'b0001.
  - `seg` = all off: 8'hFF if ACTIVE_LOW, else 8'h00.
- Write:
  - On an edge with wr_en=1: disp_reg<=data_in and shown<=1.
  - Back-to-back writes: the last one wins.
  - wr_en=0 holds disp_reg.
- Prescaler:
  - presc counts 0..SCAN_DIV-1 and wraps to 0.
  - On the edge where presc==SCAN_DIV-1, dig<=(dig+1) mod 4 (3 wraps to 0).
  - SCAN_DIV=1: dig advances every cycle.
  - presc is 16 bits wide.
- Output register: on each edge, `an` and `seg` load from the current (pre-edge) dig, disp_reg, shown and halt. Consequences:
  - 1-cycle latency from any state change to the pins.
  - A write at edge k appears on `seg` at edge k+1, provided the written digit is the selected one.
- Segment decode, active-high g..a for nibble values 0..F:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - ACTIVE_LOW inverts all 8 seg bits and all 4 an bits.
- Blanking (segments g..a off), in priority order:
  1. shown=0: all digits blank.
  2. LZB=1 and i>=1 and nibbles i..3 are all zero: digit i blank.
  3. Digit 0 is never blanked once shown=1.
- dp:
  - Lit only when dig==0 and halt=1.
  - Independent of shown and blanking.
  - Off on all other digits.
- Simultaneous events:
  - A write and a digit advance on the same edge are both applied.
  - The next output load uses the new dig and the new disp_reg.
- Reset mid-scan: all state returns to reset values immediately, without waiting for clk. Scanning restarts at digit 0 with presc=0 after release.
- `an` is always exactly one-hot after reset, including across wrap-around.

Test Plan:
1. Reset/polarity: SCAN_DIV=4, ACTIVE_LOW=1, rst_n=0 -> an=4'b1110, seg=8'hFF. Release with no write -> an rotates 1110→1101→1011→0111→1110 every 4 cycles; seg stays 8'hFF.
2. Write/latency: wr_en=1, data_in=16'h1A3F at an edge while dig==0 -> next edge seg=~8'h71 (F). Then, as dig advances, digits 1/2/3 show ~8'h4F (3), ~8'h77 (A) and ~8'h06 (1).
3. Leading-zero blanking: LZB=1, write 16'h0050 -> digits 3 and 2 show seg=8'hFF, digit 1 shows ~8'h6D, digit 0 shows ~8'h3F. Write 16'h0000 -> only digit 0 shows ~8'h3F.
4. Halt dp: halt=1 with disp 16'h0007 -> digit 0 seg=~8'h87; digits 1..3 have dp off. Also check halt=1 before any write -> digit 0 seg=8'h7F (dp only).
5. Simultaneous and wrap: SCAN_DIV=1, ACTIVE_LOW=0, write 16'h4321 on the edge where dig goes 3→0 -> an=4'b0001 and seg=8'h06 on the following cycle; an then cycles every clock.
6. Async reset mid-scan: assert rst_n=0 between clk edges while dig=2 with disp 16'hBEEF -> outputs go to reset values immediately; after release, digit 0 shows blank until the next wr_en.
